// File: rtl/coso_pkg.sv
// Shared definitions for the coherent sampler counter: parameter defaults and
// the handshake FSM state encoding.
package coso_pkg;

    localparam int unsigned CSCntLengthDef = 16;
    localparam int unsigned SyncStagesDef  = 2;
    localparam int unsigned FiltLenDef     = 3;
    localparam int unsigned OvrLengthDef   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } cs_state_e;

endpackage

// File: rtl/beat_edge_filter.sv
// Beat edge qualifier: synchronises the asynchronous beat level, tracks how long
// it has been low, and emits a registered one-cycle pulse for each rising edge
// preceded by at least FiltLen low cycles. Shorter low runs are treated as glitches.
module beat_edge_filter
    import coso_pkg::*;
#(
    parameter int unsigned SyncStages = SyncStagesDef,
    parameter int unsigned FiltLen    = FiltLenDef
) (
    input  logic clk,
    input  logic rst_n,
    input  logic beat_i,
    output logic acc_o
);

    localparam int unsigned RunW = $clog2(FiltLen + 1);

    logic [SyncStages-1:0] sync_q;
    logic                  beat_s;
    logic                  prev_q;
    logic [RunW-1:0]       low_run_q;
    logic                  acc_q;

    assign beat_s = sync_q[SyncStages-1];
    assign acc_o  = acc_q;

    // Synchroniser chain; beat_s is its last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], beat_i};
        end
    end

    // Low-run length (saturating) and edge detection; any high cycle clears the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b0;
            low_run_q <= '0;
            acc_q     <= 1'b0;
        end else begin
            prev_q <= beat_s;
            acc_q  <= beat_s && !prev_q && (low_run_q == RunW'(FiltLen));
            if (beat_s) begin
                low_run_q <= '0;
            end else if (low_run_q != RunW'(FiltLen)) begin
                low_run_q <= low_run_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherent_sampler_counter.sv
// Coherent sampler period counter: measures clk cycles between accepted beat
// edges and hands each period to the RO-matching controller over CSCnt/CSReq/CSAck.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no outstanding sample; next accepted edge is captured
//   ST_REQ  | CSReq high this cycle; an ack here releases straight to IDLE
//   ST_WAIT | CSCnt held, waiting for CSAck; edges here count as overruns
module coherent_sampler_counter
    import coso_pkg::*;
#(
    parameter int unsigned CSCntLength = CSCntLengthDef,
    parameter int unsigned SyncStages  = SyncStagesDef,
    parameter int unsigned FiltLen     = FiltLenDef,
    parameter int unsigned OvrLength   = OvrLengthDef
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   beatIn,
    input  logic                   CSAck,
    output logic [CSCntLength-1:0] CSCnt,
    output logic                   CSReq,
    output logic                   rawBit,
    output logic                   bitValid,
    output logic                   sat,
    output logic [OvrLength-1:0]   ovrCnt
);

    logic                   acc;
    logic [CSCntLength-1:0] cnt_q;
    logic                   sat_q;
    cs_state_e              state_q;
    logic [CSCntLength-1:0] cs_cnt_q;
    logic                   cs_req_q;
    logic [OvrLength-1:0]   ovr_q;
    logic                   first_seen_q;

    beat_edge_filter #(
        .SyncStages (SyncStages),
        .FiltLen    (FiltLen)
    ) u_filt (
        .clk    (clk),
        .rst_n  (rst_n),
        .beat_i (beatIn),
        .acc_o  (acc)
    );

    // Period counter: restarts at 1 on every accepted edge, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= CSCntLength'(1);
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky saturation flag, raised whenever an accepted period hit the ceiling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (acc && (cnt_q == '1)) begin
            sat_q <= 1'b1;
        end
    end

    // Handshake FSM with registered CSCnt/CSReq/overrun outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cs_cnt_q     <= '0;
            cs_req_q     <= 1'b0;
            ovr_q        <= '0;
            first_seen_q <= 1'b0;
        end else begin
            cs_req_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        if (!first_seen_q) begin
                            // The first edge after reset has no valid start point.
                            first_seen_q <= 1'b1;
                        end else begin
                            cs_cnt_q <= cnt_q;
                            cs_req_q <= 1'b1;
                            state_q  <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (acc && (ovr_q != '1)) begin
                        ovr_q <= ovr_q + 1'b1;
                    end
                    state_q <= CSAck ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (acc && (ovr_q != '1)) begin
                        ovr_q <= ovr_q + 1'b1;
                    end
                    if (CSAck) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign CSCnt    = cs_cnt_q;
    assign CSReq    = cs_req_q;
    assign rawBit   = cs_cnt_q[0];
    assign bitValid = cs_req_q;
    assign sat      = sat_q;
    assign ovrCnt   = ovr_q;

endmodule

// File: tb/tb_coherent_sampler_counter.sv
// Bench for coherent_sampler_counter. Two instances share the beat input:
// A (8-bit count, 3-cycle filter) and B (16-bit count, 1-cycle filter).
// An event-level model predicts every output each cycle; directed literals
// pin the model at the interesting points.
module tb_coherent_sampler_counter;

    localparam int S  = 2;
    localparam int WA = 8;
    localparam int WB = 16;
    localparam int OV = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic beat_in = 1'b0;
    logic ack_a = 1'b0;
    logic ack_b = 1'b0;

    logic [WA-1:0] cnt_a;
    logic          req_a, raw_a, bv_a, sat_a;
    logic [OV-1:0] ovr_a;
    logic [WB-1:0] cnt_b;
    logic          req_b, raw_b, bv_b, sat_b;
    logic [OV-1:0] ovr_b;

    always #5 clk = ~clk;

    coherent_sampler_counter #(
        .CSCntLength (WA), .SyncStages (S), .FiltLen (3), .OvrLength (OV)
    ) u_dut_a (
        .clk (clk), .rst_n (rst_n), .beatIn (beat_in), .CSAck (ack_a),
        .CSCnt (cnt_a), .CSReq (req_a), .rawBit (raw_a), .bitValid (bv_a),
        .sat (sat_a), .ovrCnt (ovr_a)
    );

    coherent_sampler_counter #(
        .CSCntLength (WB), .SyncStages (S), .FiltLen (1), .OvrLength (OV)
    ) u_dut_b (
        .clk (clk), .rst_n (rst_n), .beatIn (beat_in), .CSAck (ack_b),
        .CSCnt (cnt_b), .CSReq (req_b), .rawBit (raw_b), .bitValid (bv_b),
        .sat (sat_b), .ovrCnt (ovr_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // bin[n]: beatIn sampled at posedge n; bs[n]: synchronised beat during cycle n.
    bit     bin[$];
    bit     bs[$];
    int     cyc;
    int     fl[2]   = '{3, 1};
    longint maxc[2] = '{255, 65535};
    longint last_acc[2];
    longint m_cnt[2];
    longint m_ovr[2];
    bit     fs[2];
    bit     busy[2];
    bit     m_req[2];
    bit     m_sat[2];
    int     reqcnt_a = 0;
    int     reqcnt_b = 0;

    function automatic void model_reset();
        bin.delete(); bs.delete();
        bin.push_back(1'b0); bs.push_back(1'b0);
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            last_acc[i] = 0; m_cnt[i] = 0; m_ovr[i] = 0;
            fs[i] = 0; busy[i] = 0; m_req[i] = 0; m_sat[i] = 0;
        end
    endfunction

    // Edge accepted in cycle k: synchronised beat rose in cycle k-1 after f low cycles.
    function automatic bit acc_at(int k, int f);
        if (k - 1 - f < 0) return 1'b0;
        if (!bs[k-1]) return 1'b0;
        for (int j = k - 1 - f; j <= k - 2; j++) begin
            if (bs[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step(bit a0, bit a1);
        int  k;
        bit  a, ack, was_busy;
        longint p;
        cyc++;
        bin.push_back(beat_in);
        bs.push_back((cyc - S + 1 >= 1) ? bin[cyc-S+1] : 1'b0);
        k = cyc - 1;
        for (int i = 0; i < 2; i++) begin
            a        = (k >= 0) && acc_at(k, fl[i]);
            ack      = (i == 0) ? a0 : a1;
            was_busy = busy[i];
            m_req[i] = 0;
            if (was_busy && ack) busy[i] = 0;
            if (a) begin
                p = k - last_acc[i];
                if (p > maxc[i]) p = maxc[i];
                last_acc[i] = k;
                if (p == maxc[i]) m_sat[i] = 1;
                if (!fs[i]) begin
                    fs[i] = 1;
                end else if (was_busy) begin
                    if (m_ovr[i] < 255) m_ovr[i]++;
                end else begin
                    m_cnt[i] = p; m_req[i] = 1; busy[i] = 1;
                end
            end
        end
    endfunction

    task automatic compare_all();
        chk("A.CSCnt",    cnt_a, m_cnt[0]);
        chk("A.CSReq",    req_a, m_req[0]);
        chk("A.rawBit",   raw_a, m_cnt[0] & 1);
        chk("A.bitValid", bv_a,  m_req[0]);
        chk("A.sat",      sat_a, m_sat[0]);
        chk("A.ovrCnt",   ovr_a, m_ovr[0]);
        chk("B.CSCnt",    cnt_b, m_cnt[1]);
        chk("B.CSReq",    req_b, m_req[1]);
        chk("B.rawBit",   raw_b, m_cnt[1] & 1);
        chk("B.bitValid", bv_b,  m_req[1]);
        chk("B.sat",      sat_b, m_sat[1]);
        chk("B.ovrCnt",   ovr_b, m_ovr[1]);
    endtask

    // Per-cycle compare against the model, and async reset handling.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                #1;
                compare_all();
            end else begin
                model_step(ack_a, ack_b);
                #1;
                compare_all();
                if (req_a) reqcnt_a++;
                if (req_b) reqcnt_b++;
            end
        end
    end

    // ---------------- ack responders ----------------
    bit auto_a = 1, auto_b = 1, man_a = 0, pend_a = 0, pend_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            ack_a  = (auto_a && pend_a) || man_a;
            pend_a = req_a;
            ack_b  = auto_b && pend_b;
            pend_b = req_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic beat(input int h, input int l);
        beat_in = 1'b1; idle(h);
        beat_in = 1'b0; idle(l);
    endtask

    task automatic beat_glitch(input int h, input int l1, input int g, input int l2);
        beat_in = 1'b1; idle(h);
        beat_in = 1'b0; idle(l1);
        beat_in = 1'b1; idle(g);
        beat_in = 1'b0; idle(l2);
    endtask

    task automatic pulse_ack_a();
        man_a = 1'b1; idle(1);
        man_a = 1'b0;
    endtask

    initial begin
        int mark;
        int lat;
        bit found;

        // Reset state
        idle(3);
        chk("rst.A.CSCnt", cnt_a, 0);
        chk("rst.A.CSReq", req_a, 0);
        chk("rst.A.sat",   sat_a, 0);
        chk("rst.A.ovr",   ovr_a, 0);
        rst_n = 1'b1;
        idle(5);

        // 1: clean beat, period 10; first edge silent
        mark = reqcnt_a;
        repeat (4) beat(5, 5);
        chk("t1.A.reqs",  reqcnt_a - mark, 3);
        chk("t1.A.CSCnt", cnt_a, 10);
        chk("t1.A.ovr",   ovr_a, 0);

        // 2: one-cycle glitch after only 2 low cycles, true period 15
        mark = reqcnt_a;
        beat_glitch(5, 2, 1, 7);
        beat(5, 5);
        chk("t2.A.reqs",  reqcnt_a - mark, 2);
        chk("t2.A.CSCnt", cnt_a, 15);

        // 3: ack withheld over three 12-cycle beats
        beat(6, 6);
        auto_a = 1'b0;
        mark = reqcnt_a;
        beat(6, 6);
        beat(6, 6);
        beat_in = 1'b1; idle(6);
        beat_in = 1'b0; idle(3);
        chk("t3.A.reqs",  reqcnt_a - mark, 1);
        chk("t3.A.ovr",   ovr_a, 2);
        chk("t3.A.CSCnt", cnt_a, 12);
        pulse_ack_a();
        idle(2);
        auto_a = 1'b1;
        mark = reqcnt_a;
        beat(6, 6);
        chk("t3.A.after_reqs", reqcnt_a - mark, 1);
        chk("t3.A.after_cnt",  cnt_a, 12);
        chk("t3.A.after_ovr",  ovr_a, 2);

        // 4: period 300 saturates the 8-bit counter; then period 20
        beat(6, 294);
        chk("t4.A.sat_before", sat_a, 0);
        beat(6, 14);
        chk("t4.A.CSCnt", cnt_a, 255);
        chk("t4.A.sat",   sat_a, 1);
        chk("t4.B.CSCnt", cnt_b, 300);
        chk("t4.B.sat",   sat_b, 0);
        beat(6, 14);
        chk("t4.A.CSCnt20", cnt_a, 20);
        chk("t4.A.sticky",  sat_a, 1);

        // 5: reset in the middle of WAIT
        auto_a = 1'b0;
        beat_in = 1'b1; idle(6);
        beat_in = 1'b0; idle(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5.A.CSCnt", cnt_a, 0);
        chk("t5.A.CSReq", req_a, 0);
        chk("t5.A.sat",   sat_a, 0);
        chk("t5.A.ovr",   ovr_a, 0);
        @(negedge clk);
        rst_n  = 1'b1;
        auto_a = 1'b1;
        idle(5);
        mark = reqcnt_a;
        beat(6, 6);
        chk("t5.A.silent", reqcnt_a - mark, 0);
        beat(6, 6);
        chk("t5.A.reqs",  reqcnt_a - mark, 1);
        chk("t5.A.CSCnt", cnt_a, 12);

        // 6: latency with the 1-cycle filter, odd period 13
        idle(1);
        beat_in = 1'b1;
        lat = 0;
        found = 1'b0;
        @(posedge clk);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clk);
            #1;
            if (!found && req_b) begin
                lat = j;
                found = 1'b1;
            end
        end
        chk("t6.B.latency", lat, 3);
        chk("t6.B.CSCnt",   cnt_b, 13);
        chk("t6.B.rawBit",  raw_b, 1);
        @(negedge clk);
        beat_in = 1'b0;
        idle(10);
        chk("t6.A.CSCnt", cnt_a, 13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
